sram_req_arbiter: RTL and testbench

Two-to-one arbiter that shares a single SRAM-like request port between the CPU's instruction-fetch and data-access SRAM-like masters. It sits between `cpu_sram` and the AXI bridge (or a unified cache) when only one downstream port is available. It issues requests with data-side priority and a starvation guard for fetch, and tracks up to `DEPTH` outstanding transactions. In-order downstream responses are routed back to the master that issued each one.

---
 rtl/sram_req_arbiter.sv | 153 +++++++++++++++
 tb/tb_sram_req_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_arbiter.sv
// Two-to-one SRAM-like request arbiter: data-priority grant with a fetch starvation
// guard, plus an in-order source FIFO that routes each downstream response to its master.
module sram_req_arbiter #(
  parameter int DEPTH  = 4,
  parameter int STREAK = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STREAK + 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STREAK);

  typedef enum logic [1:0] {
    UNLOCKED,
    LOCKED_INST,
    LOCKED_DATA
  } lock_t;

  lock_t          state, state_next;
  logic           grant_valid;
  logic           grant_data;
  logic [SW-1:0]  streak;

  logic [DEPTH-1:0] src_q;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             full, empty, head_data;
  logic             push, pop;
  logic             inst_accept, data_accept;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign head_data = src_q[rd_ptr];

  // Lock register: holds the grant on a source until the downstream accepts it.
  always_ff @(posedge clk) begin
    if (reset) state <= UNLOCKED;
    else       state <= state_next;
  end

  always_comb begin
    grant_valid = 1'b0;
    grant_data  = 1'b0;
    state_next  = state;
    unique case (state)
      LOCKED_INST: begin
        grant_valid = 1'b1;
        grant_data  = 1'b0;
        if (m_addr_ok) state_next = UNLOCKED;
      end
      LOCKED_DATA: begin
        grant_valid = 1'b1;
        grant_data  = 1'b1;
        if (m_addr_ok) state_next = UNLOCKED;
      end
      default: begin
        if (data_req && !(inst_req && streak == STREAK_MAX)) begin
          grant_valid = 1'b1;
          grant_data  = 1'b1;
        end else if (inst_req) begin
          grant_valid = 1'b1;
        end
        if (m_req && !m_addr_ok)
          state_next = grant_data ? LOCKED_DATA : LOCKED_INST;
      end
    endcase
  end

  assign m_req   = grant_valid & ~full & ~reset;
  assign m_wr    = reset ? 1'b0  : (grant_data ? data_wr    : inst_wr);
  assign m_size  = reset ? 2'b0  : (grant_data ? data_size  : inst_size);
  assign m_wstrb = reset ? 4'b0  : (grant_data ? data_wstrb : inst_wstrb);
  assign m_addr  = reset ? 32'b0 : (grant_data ? data_addr  : inst_addr);
  assign m_wdata = reset ? 32'b0 : (grant_data ? data_wdata : inst_wdata);

  assign inst_accept  = m_req & m_addr_ok & ~grant_data;
  assign data_accept  = m_req & m_addr_ok &  grant_data;
  assign inst_addr_ok = inst_accept;
  assign data_addr_ok = data_accept;

  assign push = inst_accept | data_accept;
  assign pop  = m_data_ok & ~empty & ~reset;

  assign inst_data_ok = pop & ~head_data;
  assign data_data_ok = pop &  head_data;
  assign inst_rdata   = inst_data_ok ? m_rdata : 32'b0;
  assign data_rdata   = data_data_ok ? m_rdata : 32'b0;

  // Counts data grants that overtook a waiting fetch; at STREAK fetch gets the next grant.
  always_ff @(posedge clk) begin
    if (reset)
      streak <= '0;
    else if (!inst_req || inst_accept)
      streak <= '0;
    else if (data_accept && streak != STREAK_MAX)
      streak <= streak + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) src_q[wr_ptr] <= grant_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter (DEPTH=4, STREAK=4): grant order, locking,
// backpressure, response routing and reset behaviour.
module tb_sram_req_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_addr, inst_wdata;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        m_req, m_wr;
  logic [1:0]  m_size;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata;
  logic        m_addr_ok, m_data_ok;
  logic [31:0] m_rdata;

  int checks = 0;
  int errors = 0;
  logic exp_inst, prev_inst;

  sram_req_arbiter #(.DEPTH(4), .STREAK(4)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ir, input logic [31:0] ia,
                               input logic dr, input logic [31:0] da,
                               input logic aok, input logic dok,
                               input logic [31:0] rd);
    inst_req  = ir;
    inst_addr = ia;
    data_req  = dr;
    data_addr = da;
    m_addr_ok = aok;
    m_data_ok = dok;
    m_rdata   = rd;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    inst_wr    = 1'b0;
    inst_size  = 2'd2;
    inst_wstrb = 4'hF;
    inst_wdata = 32'h0;
    data_wr    = 1'b1;
    data_size  = 2'd2;
    data_wstrb = 4'hF;
    data_wdata = 32'hCAFE_BABE;

    // Outputs held at zero while reset is high, even with active inputs
    reset = 1'b1;
    applyStimulus(1, 32'hBFC0_0000, 1, 32'h2000_0000, 1, 1, 32'hFFFF_FFFF);
    tick();
    checkOutput("rst_m_req", m_req, 0);
    checkOutput("rst_m_addr", m_addr, 0);
    checkOutput("rst_m_wr", m_wr, 0);
    checkOutput("rst_inst_aok", inst_addr_ok, 0);
    checkOutput("rst_data_aok", data_addr_ok, 0);
    checkOutput("rst_inst_dok", inst_data_ok, 0);
    checkOutput("rst_data_rdata", data_rdata, 0);
    tick();
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("idle_m_req", m_req, 0);
    tick();

    // Single fetch then its response
    applyStimulus(1, 32'hBFC0_0000, 0, 0, 1, 0, 0);
    checkOutput("t1_m_req", m_req, 1);
    checkOutput("t1_m_addr", m_addr, 32'hBFC0_0000);
    checkOutput("t1_inst_aok", inst_addr_ok, 1);
    checkOutput("t1_data_aok", data_addr_ok, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h3C1D_0001);
    checkOutput("t1_inst_dok", inst_data_ok, 1);
    checkOutput("t1_inst_rdata", inst_rdata, 32'h3C1D_0001);
    checkOutput("t1_data_dok", data_data_ok, 0);
    tick();

    // Both requesting: D,D,D,D,I,D,D,D,D,I; each response pops the previous grant
    prev_inst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      exp_inst = (i == 4) || (i == 9);
      applyStimulus(1, 32'h1000_0000, 1, 32'h2000_0000, 1, (i > 0), 32'h5000_0000 + 32'(i));
      checkOutput("arb_inst_aok", inst_addr_ok, exp_inst);
      checkOutput("arb_data_aok", data_addr_ok, !exp_inst);
      checkOutput("arb_m_addr", m_addr, exp_inst ? 32'h1000_0000 : 32'h2000_0000);
      if (i > 0) checkOutput("arb_inst_dok", inst_data_ok, prev_inst);
      prev_inst = exp_inst;
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h7777_0000);
    checkOutput("arb_last_inst_dok", inst_data_ok, 1);
    checkOutput("arb_last_rdata", inst_rdata, 32'h7777_0000);
    tick();

    // Data request stalled 3 cycles stays locked while fetch arrives
    applyStimulus(0, 0, 1, 32'h2000_0004, 0, 0, 0);
    checkOutput("lk_m_addr_c1", m_addr, 32'h2000_0004);
    checkOutput("lk_data_aok_c1", data_addr_ok, 0);
    tick();
    applyStimulus(1, 32'h1000_0004, 1, 32'h2000_0004, 0, 0, 0);
    checkOutput("lk_m_addr_c2", m_addr, 32'h2000_0004);
    checkOutput("lk_m_wr_c2", m_wr, 1);
    tick();
    applyStimulus(1, 32'h1000_0004, 1, 32'h2000_0004, 0, 0, 0);
    checkOutput("lk_m_addr_c3", m_addr, 32'h2000_0004);
    checkOutput("lk_inst_aok_c3", inst_addr_ok, 0);
    tick();
    applyStimulus(1, 32'h1000_0004, 1, 32'h2000_0004, 1, 0, 0);
    checkOutput("lk_data_aok_c4", data_addr_ok, 1);
    checkOutput("lk_inst_aok_c4", inst_addr_ok, 0);
    checkOutput("lk_m_wdata_c4", m_wdata, 32'hCAFE_BABE);
    tick();
    applyStimulus(1, 32'h1000_0004, 0, 0, 1, 0, 0);
    checkOutput("lk_inst_aok_c5", inst_addr_ok, 1);
    checkOutput("lk_m_addr_c5", m_addr, 32'h1000_0004);
    checkOutput("lk_m_wr_c5", m_wr, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 32'hD000_0001);
    checkOutput("lk_resp1_data", data_data_ok, 1);
    checkOutput("lk_resp1_inst", inst_data_ok, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 32'hD000_0002);
    checkOutput("lk_resp2_inst", inst_data_ok, 1);
    checkOutput("lk_resp2_data", data_data_ok, 0);
    tick();

    // Backpressure: four accepts fill the FIFO
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 1, 32'h3000_0000, 1, 0, 0);
      checkOutput("bp_fill_aok", data_addr_ok, 1);
      tick();
    end
    applyStimulus(0, 0, 1, 32'h3000_0000, 1, 0, 0);
    checkOutput("bp_full_m_req", m_req, 0);
    checkOutput("bp_full_aok", data_addr_ok, 0);
    tick();
    applyStimulus(0, 0, 1, 32'h3000_0000, 1, 1, 32'hB000_0000);
    checkOutput("bp_pop_m_req", m_req, 0);
    checkOutput("bp_pop_dok", data_data_ok, 1);
    tick();
    applyStimulus(0, 0, 1, 32'h3000_0000, 1, 0, 0);
    checkOutput("bp_resume_m_req", m_req, 1);
    checkOutput("bp_resume_aok", data_addr_ok, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 1, 32'hB000_0001 + 32'(i));
      checkOutput("bp_drain_dok", data_data_ok, 1);
      tick();
    end

    // Interleaved I,D,I then in-order responses
    applyStimulus(1, 32'h1000_0010, 0, 0, 1, 0, 0);
    checkOutput("il_acc1", inst_addr_ok, 1);
    tick();
    applyStimulus(0, 0, 1, 32'h2000_0010, 1, 0, 0);
    checkOutput("il_acc2", data_addr_ok, 1);
    tick();
    applyStimulus(1, 32'h1000_0014, 0, 0, 1, 0, 0);
    checkOutput("il_acc3", inst_addr_ok, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 32'hA000_0001);
    checkOutput("il_r1_inst", inst_data_ok, 1);
    checkOutput("il_r1_data", data_data_ok, 0);
    checkOutput("il_r1_rdata", inst_rdata, 32'hA000_0001);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 32'hA000_0002);
    checkOutput("il_r2_data", data_data_ok, 1);
    checkOutput("il_r2_inst", inst_data_ok, 0);
    checkOutput("il_r2_rdata", data_rdata, 32'hA000_0002);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 32'hA000_0003);
    checkOutput("il_r3_inst", inst_data_ok, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 32'hA000_0004);
    checkOutput("sp1_inst_dok", inst_data_ok, 0);
    checkOutput("sp1_data_dok", data_data_ok, 0);
    checkOutput("sp1_data_rdata", data_rdata, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 32'hA000_0005);
    checkOutput("sp2_inst_dok", inst_data_ok, 0);
    checkOutput("sp2_data_dok", data_data_ok, 0);
    tick();

    // Reset with two transactions outstanding discards them
    applyStimulus(1, 32'h1000_0020, 0, 0, 1, 0, 0);
    checkOutput("mr_acc1", inst_addr_ok, 1);
    tick();
    applyStimulus(0, 0, 1, 32'h2000_0020, 1, 0, 0);
    checkOutput("mr_acc2", data_addr_ok, 1);
    tick();
    reset = 1'b1;
    applyStimulus(1, 32'h1000_0024, 1, 32'h2000_0024, 1, 1, 32'hEEEE_0000);
    checkOutput("mr_m_req", m_req, 0);
    checkOutput("mr_m_addr", m_addr, 0);
    checkOutput("mr_inst_dok", inst_data_ok, 0);
    checkOutput("mr_data_dok", data_data_ok, 0);
    checkOutput("mr_data_aok", data_addr_ok, 0);
    tick();
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 1, 32'hEEEE_0001);
    checkOutput("pr_inst_dok", inst_data_ok, 0);
    checkOutput("pr_data_dok", data_data_ok, 0);
    tick();
    applyStimulus(1, 32'h1000_0030, 0, 0, 1, 0, 0);
    checkOutput("pr_m_req", m_req, 1);
    checkOutput("pr_inst_aok", inst_addr_ok, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
